cdc_cmd_parser: RTL and testbench
=================================

// Module: cdc_cmd_parser
// PURPOSE
//  Host-to-device side of the USB CDC serial link: consumes the OUT byte stream of usb_cdc
//  (out_data_o/out_valid_o/out_ready_i) and decodes ASCII command lines "<letter><hex>*<CR|LF>".
//  Each well-formed line yields one command (opcode + numeric argument) on a valid/ready port.
//  Malformed lines are discarded up to the next terminator and flagged.
//  Runs in the usb_cdc application clock domain.
// PARAMETERS
//  ARG_DIGITS  8  max hex digits per argument; localparam ARG_W = 4*ARG_DIGITS
// PORTS
//  clk_i        in   1      application clock
//  rstn_i       in   1      asynchronous, active-low reset
//  rx_data_i    in   8      byte from usb_cdc out_data_o
//  rx_valid_i   in   1      from usb_cdc out_valid_o
//  rx_ready_o   out  1      to usb_cdc out_ready_i; byte transfers when rx_valid_i & rx_ready_o
//  cmd_valid_o  out  1      decoded command available
//  cmd_op_o     out  8      opcode, upper-case ASCII 'A'..'Z'
//  cmd_arg_o    out  ARG_W  argument, right-aligned, 0 if no digits given
//  cmd_ready_i  in   1      consumer accepts command when cmd_valid_o & cmd_ready_i
//  err_o        out  1      one-cycle pulse on line error
//  err_code_o   out  2      1=BADOP 2=BADHEX 3=OVF; holds last error until next error
//  echo_data_o  out  8      [CDC_CMD_ECHO_EN only] echoed byte, to usb_cdc in_data_i
//  echo_valid_o out  1      [CDC_CMD_ECHO_EN only] to usb_cdc in_valid_i
//  echo_ready_i in   1      [CDC_CMD_ECHO_EN only] from usb_cdc in_ready_o
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; all outputs 0 except rx_ready_o=1 after release.
//  FSM, one byte considered per accepted transfer:
//   IDLE:    CR/LF/space ignored. 'A'-'Z' or 'a'-'z' -> latch opcode (folded to upper), arg<=0,
//            digit count<=0, go ARG. Any other byte -> err BADOP, go DISCARD.
//   ARG:     hex digit (0-9,A-F,a-f) with count<ARG_DIGITS -> arg<={arg[ARG_W-5:0],nibble},count++.
//            hex digit with count==ARG_DIGITS -> err OVF, go DISCARD. CR or LF -> go EMIT.
//            any other byte -> err BADHEX, go DISCARD.
//   EMIT:    cmd_valid_o=1, cmd_op_o/cmd_arg_o stable; rx_ready_o=0 (backpressure host).
//            on cmd_ready_i -> IDLE next cycle, cmd_valid_o=0.
//   DISCARD: swallow bytes; CR or LF -> IDLE. The terminator itself raises no error.
//  Latency: terminator accepted at cycle N -> cmd_valid_o=1 at N+1; zero-cycle if cmd_ready_i=1 at N+1.
//  CR immediately followed by LF: LF is an empty line in IDLE, silently ignored.
//  err_o pulses in the cycle after the offending byte is accepted; never while in EMIT.
//  rx_ready_o = (state!=EMIT) [& echo slot free when echo enabled]; registered-free, no comb path
//  from rx_valid_i to rx_ready_o.
//  Reset mid-line or mid-EMIT: partial line and pending command dropped, no error pulse.
// CONFIGURATION
//  CDC_CMD_ECHO_EN defined: every accepted rx byte is copied into a 1-byte echo register
//   (echo_valid_o=1 next cycle, held until echo_ready_i); rx_ready_o additionally requires
//   !echo_valid_o | echo_ready_i, so echo never drops a byte. Bytes are echoed raw, incl. errors.
//  Not defined: echo ports and register absent; rx_ready_o depends only on FSM state.
// STRUCTURE
//  cdc_cmd_pkg: state encoding (IDLE/ARG/EMIT/DISCARD), ASCII constants CHAR_CR=8'h0D,
//   CHAR_LF=8'h0A, CHAR_SP=8'h20, error codes ERR_BADOP/ERR_BADHEX/ERR_OVF.
//  Sub-module hex_nibble_decode: combinational ASCII -> {is_hex, nibble[3:0]}.
//  Top holds FSM, arg shift register, digit counter, err register, optional echo register.
// TESTING
//  "L1F\r" with cmd_ready_i=1 -> one cmd: op=0x4C, arg=0x0000001F; no err_o.
//  "s\n" -> op=0x53, arg=0; "\r\n\r\n" alone -> no cmd, no err.
//  "X12G4\rA5\r" -> err BADHEX once, then cmd op='A' arg=5; bytes up to first \r discarded.
//  "W123456789\r" (9 digits, ARG_DIGITS=8) -> err OVF, no cmd; next "R\r" decodes normally.
//  "B7\r" with cmd_ready_i=0 for 10 cycles -> cmd_valid_o held, rx_ready_o=0 throughout; rx bytes
//   queued upstream are not lost and decode after acceptance.
//  With CDC_CMD_ECHO_EN, echo_ready_i stuck 0 after first byte -> rx_ready_o=0, echo_data_o holds
//   first byte; release -> full line echoed in order; assert rstn_i mid-line -> all outputs 0.

Source files
------------

// File: rtl/cdc_cmd_pkg.sv
// Shared types and constants for the USB CDC command-line parser.
// Holds the FSM state encoding, ASCII constants, error codes and character helpers.
package cdc_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARG     = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  localparam logic [1:0] ERR_BADOP  = 2'd1;
  localparam logic [1:0] ERR_BADHEX = 2'd2;
  localparam logic [1:0] ERR_OVF    = 2'd3;

  function automatic logic is_term(input logic [7:0] ch);
    return (ch == CHAR_CR) || (ch == CHAR_LF);
  endfunction

  function automatic logic is_letter(input logic [7:0] ch);
    return ((ch >= 8'h41) && (ch <= 8'h5A)) || ((ch >= 8'h61) && (ch <= 8'h7A));
  endfunction

  // Clearing bit 5 folds a-z onto A-Z and leaves A-Z untouched.
  function automatic logic [7:0] to_upper(input logic [7:0] ch);
    return ch & 8'hDF;
  endfunction

endpackage

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' -> 4-bit value.
module hex_nibble_decode (
  input  logic [7:0] data_i,
  output logic       is_hex_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_hex_o = 1'b0;
    nibble_o = 4'd0;
    if ((data_i >= 8'h30) && (data_i <= 8'h39)) begin
      is_hex_o = 1'b1;
      nibble_o = data_i[3:0];
    end else if (((data_i >= 8'h41) && (data_i <= 8'h46)) ||
                 ((data_i >= 8'h61) && (data_i <= 8'h66))) begin
      // Low nibble of A-F / a-f is 1..6, so +9 gives 10..15.
      is_hex_o = 1'b1;
      nibble_o = data_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/cdc_cmd_parser.sv
// Decodes "<letter><hex>*<CR|LF>" lines from the CDC OUT byte stream into op/arg commands.
// Optional raw byte echo toward the CDC IN path is built when CDC_CMD_ECHO_EN is defined.
module cdc_cmd_parser
  import cdc_cmd_pkg::*;
#(
  parameter  int ARG_DIGITS = 8,
  localparam int ARG_W      = 4 * ARG_DIGITS
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  output logic             cmd_valid_o,
  output logic [7:0]       cmd_op_o,
  output logic [ARG_W-1:0] cmd_arg_o,
  input  logic             cmd_ready_i,
  output logic             err_o,
  output logic [1:0]       err_code_o
`ifdef CDC_CMD_ECHO_EN
  ,
  output logic [7:0]       echo_data_o,
  output logic             echo_valid_o,
  input  logic             echo_ready_i
`endif
);

  localparam int CNT_W = $clog2(ARG_DIGITS + 1);

  state_e           state_reg, state_next;
  logic [7:0]       op_reg, op_next;
  logic [ARG_W-1:0] arg_reg, arg_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic             accept;
  logic             echo_free;
  logic             is_hex;
  logic [3:0]       nibble;

  hex_nibble_decode u_hex (
    .data_i   (rx_data_i),
    .is_hex_o (is_hex),
    .nibble_o (nibble)
  );

`ifdef CDC_CMD_ECHO_EN
  logic [7:0] echo_data_reg;
  logic       echo_valid_reg;

  // A byte may only be taken when the echo slot is empty or draining this cycle.
  assign echo_free = !echo_valid_reg || echo_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      echo_data_reg  <= 8'd0;
      echo_valid_reg <= 1'b0;
    end else if (accept) begin
      echo_data_reg  <= rx_data_i;
      echo_valid_reg <= 1'b1;
    end else if (echo_ready_i) begin
      echo_valid_reg <= 1'b0;
    end
  end

  assign echo_data_o  = echo_data_reg;
  assign echo_valid_o = echo_valid_reg;
`else
  assign echo_free = 1'b1;
`endif

  assign rx_ready_o  = (state_reg != ST_EMIT) && echo_free;
  assign accept      = rx_valid_i && rx_ready_o;
  assign cmd_valid_o = (state_reg == ST_EMIT);
  assign cmd_op_o    = op_reg;
  assign cmd_arg_o   = arg_reg;
  assign err_o       = err_reg;
  assign err_code_o  = err_code_reg;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg    <= ST_IDLE;
      op_reg       <= 8'd0;
      arg_reg      <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      err_code_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      arg_reg      <= arg_next;
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    arg_next      = arg_reg;
    cnt_next      = cnt_reg;
    err_next      = 1'b0;
    err_code_next = err_code_reg;
    case (state_reg)
      ST_IDLE: begin
        // Terminators and spaces between lines are ignored.
        if (accept && !is_term(rx_data_i) && (rx_data_i != CHAR_SP)) begin
          if (is_letter(rx_data_i)) begin
            op_next    = to_upper(rx_data_i);
            arg_next   = '0;
            cnt_next   = '0;
            state_next = ST_ARG;
          end else begin
            err_next      = 1'b1;
            err_code_next = ERR_BADOP;
            state_next    = ST_DISCARD;
          end
        end
      end
      ST_ARG: begin
        if (accept) begin
          if (is_hex) begin
            if (cnt_reg < CNT_W'(ARG_DIGITS)) begin
              arg_next = {arg_reg[ARG_W-5:0], nibble};
              cnt_next = cnt_reg + 1'b1;
            end else begin
              err_next      = 1'b1;
              err_code_next = ERR_OVF;
              state_next    = ST_DISCARD;
            end
          end else if (is_term(rx_data_i)) begin
            state_next = ST_EMIT;
          end else begin
            err_next      = 1'b1;
            err_code_next = ERR_BADHEX;
            state_next    = ST_DISCARD;
          end
        end
      end
      ST_EMIT: begin
        if (cmd_ready_i) state_next = ST_IDLE;
      end
      ST_DISCARD: begin
        if (accept && is_term(rx_data_i)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cdc_cmd_parser.sv
// Self-checking bench for cdc_cmd_parser: directed vector table, multi-cycle corner
// sequences and randomized lines scored against a line-level reference model.
`timescale 1ns/1ps
module tb_cdc_cmd_parser;

  localparam int ARG_DIGITS = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        cmd_valid;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        cmd_ready;
  logic        err;
  logic [1:0]  err_code;
  logic        rand_mode = 1'b0;
  logic        fix_cmd_ready = 1'b1;
  logic        rnd_cmd_ready = 1'b1;
`ifdef CDC_CMD_ECHO_EN
  logic [7:0]  echo_data;
  logic        echo_valid;
  logic        echo_ready;
  logic        fix_echo_ready = 1'b1;
  logic        rnd_echo_ready = 1'b1;
  assign echo_ready = rand_mode ? rnd_echo_ready : fix_echo_ready;
`endif
  assign cmd_ready = rand_mode ? rnd_cmd_ready : fix_cmd_ready;

  cdc_cmd_parser #(.ARG_DIGITS(ARG_DIGITS)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .cmd_valid_o (cmd_valid),
    .cmd_op_o    (cmd_op),
    .cmd_arg_o   (cmd_arg),
    .cmd_ready_i (cmd_ready),
    .err_o       (err),
    .err_code_o  (err_code)
`ifdef CDC_CMD_ECHO_EN
    ,
    .echo_data_o  (echo_data),
    .echo_valid_o (echo_valid),
    .echo_ready_i (echo_ready)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: whole lines, parsed at their terminator
  typedef struct packed {logic [7:0] op; logic [31:0] arg;} cmd_t;
  byte unsigned mdl_line[$];
  cmd_t         exp_cmd[$];
  logic [1:0]   exp_err[$];
  logic [1:0]   obs_err[$];
  byte unsigned echo_q[$];

  function automatic int hexval(input byte unsigned c);
    if (c >= 48 && c <= 57) return int'(c) - 48;
    if (c >= 65 && c <= 70) return int'(c) - 55;
    if (c >= 97 && c <= 102) return int'(c) - 87;
    return -1;
  endfunction

  function automatic void model_line();
    int i = 0;
    int nd = 0;
    logic [31:0] a = 0;
    byte unsigned c;
    byte unsigned up;
    cmd_t cm;
    while (i < mdl_line.size() && mdl_line[i] == 8'h20) i++;
    if (i >= mdl_line.size()) return;
    c = mdl_line[i];
    if (!((c >= 65 && c <= 90) || (c >= 97 && c <= 122))) begin
      exp_err.push_back(2'd1);
      return;
    end
    for (int j = i + 1; j < mdl_line.size(); j++) begin
      int v;
      v = hexval(mdl_line[j]);
      if (v < 0) begin exp_err.push_back(2'd2); return; end
      if (nd == ARG_DIGITS) begin exp_err.push_back(2'd3); return; end
      a = a * 16 + 32'(v);
      nd++;
    end
    up = (c >= 97) ? c - 8'd32 : c;
    cm.op = up;
    cm.arg = a;
    exp_cmd.push_back(cm);
  endfunction

  function automatic void model_byte(input byte unsigned b);
    if (b == 8'h0D || b == 8'h0A) begin
      model_line();
      mdl_line.delete();
    end else begin
      mdl_line.push_back(b);
    end
  endfunction

  // ---------------- monitor (samples on the falling edge)
  int          acc_cyc = -10;
  logic        prev_cv = 1'b0;
  int          n_cmd = 0;
  int          n_err = 0;
  logic [7:0]  last_op = 0;
  logic [31:0] last_arg = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (err) begin
        obs_err.push_back(err_code);
        n_err++;
        $display("err code=%0d at cycle %0d", err_code, cyc);
        check("err_timing", 64'(acc_cyc), 64'(cyc - 1));
      end
      if (cmd_valid && !prev_cv) check("cmd_latency", 64'(acc_cyc), 64'(cyc - 1));
      if (cmd_valid) check("ready_in_emit", rx_ready, 0);
      if (cmd_valid && cmd_ready) begin
        n_cmd++;
        last_op = cmd_op;
        last_arg = cmd_arg;
        $display("cmd op=%c arg=%08h at cycle %0d", cmd_op, cmd_arg, cyc);
        if (exp_cmd.size() == 0) begin
          check("unexpected_cmd", 1, 0);
        end else begin
          cmd_t e;
          e = exp_cmd.pop_front();
          check("cmd_op", cmd_op, e.op);
          check("cmd_arg", cmd_arg, e.arg);
        end
      end
`ifdef CDC_CMD_ECHO_EN
      if (echo_valid && echo_ready) begin
        $display("echo byte=%02h", echo_data);
        if (echo_q.size() == 0) check("unexpected_echo", 1, 0);
        else check("echo_data", echo_data, echo_q.pop_front());
      end
`endif
      if (rx_valid && rx_ready) begin
        acc_cyc = cyc;
        model_byte(rx_data);
        echo_q.push_back(rx_data);
      end
    end
    prev_cv = cmd_valid;
  end

  always @(posedge clk) begin
    #1;
    rnd_cmd_ready = ($urandom_range(0, 3) != 0);
`ifdef CDC_CMD_ECHO_EN
    rnd_echo_ready = ($urandom_range(0, 2) != 0);
`endif
  end

  // ---------------- stimulus helpers
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 300) begin
        check("rx_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int gap_max);
    for (int i = 0; i < s.len(); i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      send_byte(s[i]);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_errs();
    check("err_count", 64'(obs_err.size()), 64'(exp_err.size()));
    while (obs_err.size() > 0 && exp_err.size() > 0)
      check("err_code_seq", obs_err.pop_front(), exp_err.pop_front());
    obs_err.delete();
    exp_err.delete();
  endtask

  logic [1:0] held_code = 2'd0;

  task automatic do_reset();
    rx_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_op", cmd_op, 0);
    check("rst_cmd_arg", cmd_arg, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
`ifdef CDC_CMD_ECHO_EN
    check("rst_echo_valid", echo_valid, 0);
    check("rst_echo_data", echo_data, 0);
`endif
    mdl_line.delete();
    exp_cmd.delete();
    exp_err.delete();
    obs_err.delete();
    echo_q.delete();
    held_code = 2'd0;
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    settle(1);
    check("rst_rx_ready", rx_ready, 1);
  endtask

  // ---------------- directed vector table
  typedef struct {
    string       line;
    int          ncmd;
    logic [7:0]  op;
    logic [31:0] arg;
    int          nerr;
    logic [1:0]  code;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int w;
    tbl[0] = '{"L1F\015",               1, 8'h4C, 32'h0000001F, 0, 2'd0};
    tbl[1] = '{"s\n",                   1, 8'h53, 32'h00000000, 0, 2'd0};
    tbl[2] = '{"\015\n\015\n",          0, 8'h00, 32'h00000000, 0, 2'd0};
    tbl[3] = '{"X12G4\015A5\015",       1, 8'h41, 32'h00000005, 1, 2'd2};
    tbl[4] = '{"\015\n",                0, 8'h00, 32'h00000000, 0, 2'd0};
    tbl[5] = '{"W123456789\015R\015",   1, 8'h52, 32'h00000000, 1, 2'd3};
    tbl[6] = '{"9\015",                 0, 8'h00, 32'h00000000, 1, 2'd1};
    tbl[7] = '{"  zFFFFFFFF\n",         1, 8'h5A, 32'hFFFFFFFF, 0, 2'd0};
    tbl[8] = '{"kdeadBEEF\015",         1, 8'h4B, 32'hDEADBEEF, 0, 2'd0};
    tbl[9] = '{"Q 1\015",               0, 8'h00, 32'h00000000, 1, 2'd2};

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      string s;
      string nm;
      s = tbl[i].line;
      n_cmd = 0;
      n_err = 0;
      send_str(s, 0);
      settle(5);
      nm = $sformatf("vec%0d", i);
      check({nm, "_ncmd"}, 64'(n_cmd), 64'(tbl[i].ncmd));
      if (tbl[i].ncmd > 0) begin
        check({nm, "_op"}, last_op, tbl[i].op);
        check({nm, "_arg"}, last_arg, tbl[i].arg);
      end
      check({nm, "_nerr"}, 64'(n_err), 64'(tbl[i].nerr));
      if (tbl[i].nerr > 0) held_code = tbl[i].code;
      check({nm, "_err_code_held"}, err_code, held_code);
    end
    check_errs();

    // Backpressure: command held 10 cycles, next line waits upstream.
    n_cmd = 0;
    fix_cmd_ready = 1'b0;
    fork
      send_str("B7\015C\015", 0);
      begin
        w = 0;
        while (!cmd_valid && w < 100) begin @(negedge clk); w++; end
        check("bp_valid_seen", cmd_valid, 1);
        repeat (10) begin
          @(negedge clk);
          check("bp_hold_valid", cmd_valid, 1);
          check("bp_hold_ready", rx_ready, 0);
          check("bp_hold_op", cmd_op, 8'h42);
          check("bp_hold_arg", cmd_arg, 32'h7);
        end
        @(posedge clk);
        #1 fix_cmd_ready = 1'b1;
      end
    join
    settle(5);
    check("bp_ncmd", 64'(n_cmd), 2);
    check("bp_last_op", last_op, 8'h43);

    // Reset mid-line drops the partial line silently.
    send_str("M12", 0);
    do_reset();
    n_cmd = 0;
    n_err = 0;
    send_str("N3\015", 0);
    settle(5);
    check("rml_ncmd", 64'(n_cmd), 1);
    check("rml_op", last_op, 8'h4E);
    check("rml_arg", last_arg, 32'h3);
    check("rml_nerr", 64'(n_err), 0);

    // Reset mid-EMIT drops the pending command.
    fix_cmd_ready = 1'b0;
    send_str("P5\015", 0);
    settle(2);
    check("rme_valid", cmd_valid, 1);
    do_reset();
    fix_cmd_ready = 1'b1;
    n_cmd = 0;
    send_str("\015Q\015", 0);
    settle(5);
    check("rme_ncmd", 64'(n_cmd), 1);
    check("rme_op", last_op, 8'h51);
    check("rme_arg", last_arg, 32'h0);

`ifdef CDC_CMD_ECHO_EN
    // Stalled echo sink blocks rx after the first byte; release drains in order.
    fix_echo_ready = 1'b0;
    fork
      send_str("E1\015", 0);
      begin
        w = 0;
        while (!echo_valid && w < 100) begin @(negedge clk); w++; end
        repeat (8) begin
          @(negedge clk);
          check("echo_stall_ready", rx_ready, 0);
          check("echo_stall_data", echo_data, 8'h45);
        end
        @(posedge clk);
        #1 fix_echo_ready = 1'b1;
      end
    join
    settle(5);
    check("echo_drained", 64'(echo_q.size()), 0);
    fix_echo_ready = 1'b0;
    send_str("F", 0);
    do_reset();
    fix_echo_ready = 1'b1;
`endif

    // Randomized lines against the reference model.
    rand_mode = 1'b1;
    for (int ln = 0; ln < 150; ln++) begin
      string s;
      string hexs;
      string junk;
      int len;
      int k;
      hexs = "0123456789abcdefABCDEF";
      junk = "G!z. #";
      s = "";
      k = $urandom_range(0, 9);
      if (k < 8) begin
        byte unsigned c;
        c = 8'(65 + $urandom_range(0, 25));
        if ($urandom_range(0, 1) == 1) c = c + 8'd32;
        s = {s, string'(c)};
      end else if (k == 8) s = {s, " "};
      else s = {s, string'(junk[$urandom_range(0, 5)])};
      len = $urandom_range(0, 11);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 19) == 0) s = {s, string'(junk[$urandom_range(0, 5)])};
        else s = {s, string'(hexs[$urandom_range(0, 21)])};
      end
      k = $urandom_range(0, 2);
      if (k == 0) s = {s, "\015"};
      else if (k == 1) s = {s, "\n"};
      else s = {s, "\015\n"};
      send_str(s, 2);
    end
    w = 0;
    while (cmd_valid && w < 200) begin @(posedge clk); w++; end
    rand_mode = 1'b0;
    settle(10);
    check("rand_cmd_left", 64'(exp_cmd.size()), 0);
    check_errs();
`ifdef CDC_CMD_ECHO_EN
    check("rand_echo_left", 64'(echo_q.size()), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation exceeded time limit, bad=%0d", bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
